// File: rtl/score_timebase.sv
// score_timebase: four-digit BCD stopwatch timebase with start/pause/clear control.
// A prescaler divides clk by TICK_DIV; each prescaler wrap advances the BCD
// counter by one, with per-digit count-enable pulses exposed on digit_tick.
// Build option: define TIMER_SAT_EN to saturate at 9999 and enter DONE;
// without it the count wraps 9999 -> 0000 and keeps running.
module score_timebase #(
    parameter logic [19:0] TICK_DIV = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] digits,
    output logic [3:0]  digit_tick,
    output logic        running,
    output logic        done
);

    localparam int unsigned DIG_W   = 4;
    localparam int unsigned NUM_DIG = 4;
    localparam int unsigned PRESC_W = 20;
    localparam int unsigned CNT_W   = DIG_W * NUM_DIG;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 20'd1);
    localparam logic [DIG_W-1:0]   DIG_NINE  = DIG_W'(9);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
`ifdef TIMER_SAT_EN
        ,
        ST_DONE  = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0]    digits_q, digits_d;
    logic                running_q, running_d;
    logic                tick_due;
    logic                tick_c;
    logic [NUM_DIG-1:0]  digit_tick_c;
    logic                stop_presc;
`ifdef TIMER_SAT_EN
    logic                at_max;
    logic                sat_hit;
    logic                done_q, done_d;
`endif

    // Tick qualification and ripple of per-digit count enables.
    always_comb begin
        tick_due = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
`ifdef TIMER_SAT_EN
        at_max  = (digits_q == 16'h9999);
        sat_hit = tick_due && at_max;
        tick_c  = tick_due && !clear && !rst && !at_max;
`else
        tick_c  = tick_due && !clear && !rst;
`endif
        digit_tick_c    = '0;
        digit_tick_c[0] = tick_c;
        for (int i = 1; i < int'(NUM_DIG); i++) begin
            digit_tick_c[i] = digit_tick_c[i-1] &&
                              (digits_q[(i-1)*int'(DIG_W) +: DIG_W] == DIG_NINE);
        end
    end

    // Next-state, prescaler and digit update.
    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        digits_d = digits_q;

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
`ifdef TIMER_SAT_EN
                if (sat_hit)     state_d = ST_DONE;
                else if (pause)  state_d = ST_PAUSE;
`else
                if (pause)       state_d = ST_PAUSE;
`endif
            end
            ST_PAUSE: begin
                if (start) state_d = ST_RUN;
            end
`ifdef TIMER_SAT_EN
            ST_DONE: begin
                state_d = ST_DONE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (clear) state_d = ST_IDLE;

        // Prescaler free-runs only in RUN; PAUSE keeps the partial period.
        if (state_q == ST_RUN) begin
            presc_d = tick_due ? '0 : presc_q + PRESC_W'(1);
        end

`ifdef TIMER_SAT_EN
        stop_presc = (state_d == ST_IDLE) || (state_d == ST_DONE);
`else
        stop_presc = (state_d == ST_IDLE);
`endif
        if (stop_presc) presc_d = '0;

        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (digit_tick_c[i]) begin
                if (digits_q[i*int'(DIG_W) +: DIG_W] >= DIG_NINE) begin
                    digits_d[i*int'(DIG_W) +: DIG_W] = '0;
                end else begin
                    digits_d[i*int'(DIG_W) +: DIG_W] =
                        digits_q[i*int'(DIG_W) +: DIG_W] + DIG_W'(1);
                end
            end
        end

        if (clear) digits_d = '0;

        running_d = (state_d == ST_RUN);
`ifdef TIMER_SAT_EN
        done_d    = (state_d == ST_DONE);
`endif
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            digits_q  <= '0;
            running_q <= 1'b0;
`ifdef TIMER_SAT_EN
            done_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            digits_q  <= digits_d;
            running_q <= running_d;
`ifdef TIMER_SAT_EN
            done_q    <= done_d;
`endif
        end
    end

    assign digits     = digits_q;
    assign digit_tick = digit_tick_c;
    assign running    = running_q;
`ifdef TIMER_SAT_EN
    assign done       = done_q;
`else
    assign done       = 1'b0;
`endif

endmodule

// File: tb/tb_score_timebase.sv
// tb_score_timebase: randomized + directed scoreboard bench for score_timebase.
// Follows TIMER_SAT_EN in the same way as the design.
module tb_score_timebase;

    localparam int TD = 4;
`ifdef TIMER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        logic [3:0]  dt;
        logic [15:0] dig;
        logic        run;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic [3:0]  digit_tick;
    logic        running;
    logic        done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Specification-level model: counter value as an integer, phase = RUN cycles mod TD.
    int m_state = M_IDLE;
    int m_phase = 0;
    int m_val   = 0;

    score_timebase #(.TICK_DIV(20'(TD))) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .clear      (clear),
        .digits     (digits),
        .digit_tick (digit_tick),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic step_model(input logic s, input logic p, input logic c, input logic r,
                              output exp_t e);
        logic [3:0] dt;
        bit tick;
        bit sat;
        int nst;
        int pw;
        dt = '0;
        if (r) begin
            m_state = M_IDLE;
            m_phase = 0;
            m_val   = 0;
        end else begin
            tick = (m_state == M_RUN) && (m_phase == TD - 1) && !c;
            sat  = 1'b0;
            if (SAT && tick && m_val == 9999) begin
                sat  = 1'b1;
                tick = 1'b0;
            end
            pw = 1;
            for (int i = 0; i < 4; i++) begin
                dt[i] = tick && ((m_val % pw) == pw - 1);
                pw = pw * 10;
            end
            nst = m_state;
            if (c) nst = M_IDLE;
            else if (s && (m_state == M_IDLE || m_state == M_PAUSE)) nst = M_RUN;
            else if (sat) nst = M_DONE;
            else if (p && m_state == M_RUN) nst = M_PAUSE;
            if (m_state == M_RUN) m_phase = (m_phase + 1) % TD;
            if (tick) m_val = (m_val + 1) % 10000;
            if (c) m_val = 0;
            m_state = nst;
            if (nst == M_IDLE || nst == M_DONE) m_phase = 0;
        end
        e.dt  = dt;
        e.dig = to_bcd(m_val);
        e.run = (m_state == M_RUN);
        e.dn  = (m_state == M_DONE);
    endtask

    // Drive one cycle of inputs after the edge and queue the expected response.
    task automatic cyc(input logic s, input logic p, input logic c, input logic r);
        exp_t e;
        @(posedge clk);
        #2;
        start = s;
        pause = p;
        clear = c;
        rst   = r;
        step_model(s, p, c, r, e);
        exp_q.push_back(e);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: digit_tick mid-cycle, registered outputs just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (digit_tick !== e.dt) begin
                    n_fail++;
                    $display("FAIL digit_tick t=%0t got=%b want=%b", $time, digit_tick, e.dt);
                end
                @(posedge clk);
                #1;
                n_checks += 3;
                if (digits !== e.dig) begin
                    n_fail++;
                    $display("FAIL digits t=%0t got=%h want=%h", $time, digits, e.dig);
                end
                if (running !== e.run) begin
                    n_fail++;
                    $display("FAIL running t=%0t got=%b want=%b", $time, running, e.run);
                end
                if (done !== e.dn) begin
                    n_fail++;
                    $display("FAIL done t=%0t got=%b want=%b", $time, done, e.dn);
                end
            end
        end
    end

    // Stimulus.
    initial begin
        // Reset and basic start latency.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(3);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(12);

        // Pause mid-period, hold, resume.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(10);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(9);

        // Run past 0009 and 0099 carries, then clear+start+pause together.
        idle_cycles(4 * 110);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        idle_cycles(20);

        // Reset mid-run, then a fresh start.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(4 * 30 + 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(10);

        // Random control pulses.
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(7) == 0), ($urandom_range(15) == 0),
                ($urandom_range(199) == 0), ($urandom_range(499) == 0));
        end

        // Full sweep to 9999 and the rollover / saturation behaviour.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        idle_cycles(TD * 10000 + 8);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        idle_cycles(6);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(4);

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        repeat (2) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
